// File: rtl/fifo_rd_streamer_pkg.sv
// Shared definitions for the FIFO read-side streamer: default widths,
// output buffer depth, occupancy type and the read-issue room test.
package fifo_rd_streamer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int BUF_DEPTH  = 2;

  // Output buffer occupancy, 0..BUF_DEPTH
  typedef logic [1:0] occ_t;

  // True when a new read can be issued without overrunning the buffer:
  // words held plus the word in flight, minus the one leaving this cycle,
  // must leave room for one more.
  function automatic logic rd_room(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (committed <= 3'd1);
  endfunction

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry output buffer: pushes land at the tail, the head entry is
// presented as stream data. A flush empties it and rewinds both pointers.
module stream_skid_buf2
  import fifo_rd_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output occ_t              occ,
  output logic [DATA_W-1:0] head_data
);

  logic              head_reg;
  logic              tail_reg;
  occ_t              occ_reg;
  logic [DATA_W-1:0] entry [BUF_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] data_reg;

      // Storage slot gi: written when it is the tail and a word is captured
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (push && !flush && (int'(tail_reg) == gi)) begin
          data_reg <= push_data;
        end
      end

      assign entry[gi] = data_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep occ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      occ_reg  <= 2'd0;
    end else if (flush) begin
      head_reg <= 1'b0;
      tail_reg <= 1'b0;
      occ_reg  <= 2'd0;
    end else begin
      if (push) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 2'd1;
        2'b01:   occ_reg <= occ_reg - 2'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign occ       = occ_reg;
  assign head_data = entry[head_reg];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Drains a FIFO read port (1-cycle read latency) into a valid/ready stream.
// Reads are only issued when the 2-entry buffer is guaranteed room for the
// returning word, so a consumer holding m_ready high sees one word per cycle.
module fifo_rd_streamer
  import fifo_rd_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  word_cnt
);

  logic             inflight_reg;
  logic             drop_reg;
  logic [CNT_W-1:0] word_cnt_reg;
  occ_t             occ;
  logic             pop;
  logic             push;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // rst_n gates the request so it drops the instant reset is asserted
  assign fifo_rd_en = rst_n & ena & ~flush & ~fifo_empty & rd_room(occ, inflight_reg, pop);

  // The returning word is kept unless it belongs to a read issued before a flush
  assign push = inflight_reg & ~drop_reg & ~flush;

  // Track the read in flight and whether a flush has orphaned it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      inflight_reg <= fifo_rd_en;
      drop_reg     <= flush ? inflight_reg : 1'b0;
    end
  end

  // Delivered-word counter; survives flush, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_reg <= '0;
    end else if (pop) begin
      word_cnt_reg <= word_cnt_reg + CNT_W'(1);
    end
  end

  assign word_cnt = word_cnt_reg;

  stream_skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .flush     (flush),
    .occ       (occ),
    .head_data (m_data)
  );

endmodule
